enc_gray_arb: RTL and testbench
===============================

Name: enc_gray_arb

Overview:
- Shares a single 10-bit binary-to-Gray conversion datapath among NREQ requesters.
- Round-robin arbitration, with an optional per-requester lock for back-to-back bursts.
- One registered output stage carrying the Gray code and the winning requester ID.
- Sits between pointer/counter producers (e.g. FIFO write/read pointer logic) and consumers of Gray-coded values.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 10, data width of binary input and Gray output
IDW, 2, width of requester ID; must equal ceil(log2(NREQ))

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester request valid
req_lock  in  NREQ  per-requester lock; sampled only on the accepted beat
req_bin  in  NREQ*WIDTH  binary values; requester i occupies bits [i*WIDTH +: WIDTH]
req_ready  out  NREQ  per-requester accept, combinational
out_valid  out  1  output register holds a result
out_ready  in  1  consumer accepts the result
out_gray  out  WIDTH  Gray-coded result
out_id  out  IDW  index of the requester that produced out_gray

Behaviour:
- Clock and reset: clk with an asynchronous active-low reset rst_n. Reset asserts immediately and deasserts synchronously to clk.
- Reset values:
  - out_valid=0, out_gray=0, out_id=0.
  - Round-robin pointer=0; FSM=ARB; lock owner=0.
  - req_ready is all zeros while rst_n=0.
- Conversion:
  - gray[WIDTH-1] = bin[WIDTH-1].
  - gray[k] = bin[k+1] ^ bin[k] for k < WIDTH-1.
  - Purely bitwise; no carry or sign.
- Accept condition: accept = !out_valid || out_ready. The output register is therefore full-throughput, with no bubble when draining and refilling in the same cycle.
- Grant:
  - At most one req_ready bit is high in any cycle.
  - req_ready[g] = accept && req_valid[g] && (g == grant index).
  - A transfer occurs on a clk edge where req_valid[i] && req_ready[i].
- Latency: the Gray result and ID appear on out_gray/out_id with out_valid=1 on the cycle after the transfer edge.
- Output holding:
  - out_valid falls on out_ready && out_valid, unless a new transfer loads the register on the same edge.
  - While out_valid && !out_ready, out_gray and out_id hold stable.
- Requester obligation: req_bin[i] and req_valid[i] must stay stable until accepted. The bench checks this; the block does not.
- FSM state ARB:
  - Grant goes to the first requester with req_valid=1, searching from the pointer upward, mod NREQ.
  - On a transfer from requester i, the pointer becomes (i+1) mod NREQ.
  - If req_lock[i]=1 on that beat, go to LOCK with owner=i; otherwise stay in ARB.
- FSM state LOCK:
  - Only the owner can be granted; all other requests wait.
  - A transfer from the owner with req_lock=0 moves to ARB. The pointer is already owner+1.
  - If req_valid[owner] is low in any cycle while in LOCK, return to ARB on the next edge. No grant is made that cycle.
  - The pointer is not advanced while locked.
- Stall: when accept=0, req_ready is all zeros, and the FSM and pointer hold.
- No requests: when no req_valid bit is set, nothing changes except normal output draining.
- Simultaneous events: out_ready drain plus a new transfer on the same edge loads the new value and keeps out_valid=1.
- Wrap-around: the pointer wraps from NREQ-1 to 0. With NREQ not a power of two, IDs at or above NREQ never appear.
- Reset mid-operation:
  - Any held output is dropped; out_valid=0 immediately (asynchronous).
  - FSM returns to ARB and pointer to 0.
  - A requester whose beat was not yet accepted must re-present it.

Test Plan:
1. Single request, requester 2, bin=10'h2AA, out_ready=1 -> req_ready[2] high that cycle; next cycle out_valid=1, out_gray=10'h3FF, out_id=2.
2. All four requesters valid continuously with 10'h000, 10'h155, 10'h3FF, 10'h001, out_ready=1 -> grant order 0,1,2,3,0…; outputs 10'h000, 10'h1FF, 10'h200, 10'h001; one result per cycle.
3. Back-pressure: out_ready=0 for 5 cycles with requesters 0 and 1 valid -> first result holds stable; req_ready all zeros for 4 cycles; on out_ready=1, drain and refill on the same edge, out_valid stays 1.
4. Lock: requester 1 sends 3 beats with req_lock=1,1,0 while requesters 0 and 3 are also valid -> outputs id 1,1,1, then 3, then 0.
5. Lock abort: requester 2 locks, then drops req_valid for one cycle -> FSM returns to ARB; next grant goes to 3, since the pointer is 3.
6. Reset mid-operation: assert rst_n=0 while out_valid=1 and in LOCK -> out_valid=0 immediately; after release, first grant goes to requester 0 regardless of the earlier pointer.

Source files
------------

// File: rtl/enc_gray_arb.sv
// Round-robin arbiter (with burst lock) feeding one shared binary-to-Gray converter.
// One cycle latency to the registered output; req_ready drops while the output register is full and not draining.
module enc_gray_arb #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 10,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0]       req_lock,
  input  logic [NREQ*WIDTH-1:0] req_bin,
  output logic [NREQ-1:0]       req_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_gray,
  output logic [IDW-1:0]        out_id
);

  typedef enum logic {ARB, LOCK} state_t;

  state_t           state, state_nxt;
  logic [IDW-1:0]   ptr, ptr_nxt;
  logic [IDW-1:0]   owner, owner_nxt;
  logic             accept;
  logic             gnt_vld;
  logic [IDW-1:0]   gnt_id;
  logic             xfer;
  logic [WIDTH-1:0] gnt_bin;

  assign accept = !out_valid || out_ready;

  // Descending scan so the requester closest to the pointer is the last (winning) assignment.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    if (state == LOCK) begin
      gnt_vld = req_valid[owner];
      gnt_id  = owner;
    end else begin
      for (int k = NREQ - 1; k >= 0; k--) begin
        if (req_valid[(int'(ptr) + k) % NREQ]) begin
          gnt_vld = 1'b1;
          gnt_id  = IDW'((int'(ptr) + k) % NREQ);
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    xfer      = rst_n && accept && gnt_vld;
    if (xfer) req_ready[gnt_id] = 1'b1;
  end

  assign gnt_bin = req_bin[int'(gnt_id)*WIDTH +: WIDTH];

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    owner_nxt = owner;
    case (state)
      ARB: begin
        if (xfer) begin
          ptr_nxt = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
          if (req_lock[gnt_id]) begin
            state_nxt = LOCK;
            owner_nxt = gnt_id;
          end
        end
      end
      LOCK: begin
        // Owner giving up valid abandons the burst; the pointer already sits past the owner.
        if (!req_valid[owner]) state_nxt = ARB;
        else if (xfer && !req_lock[owner]) state_nxt = ARB;
      end
      default: state_nxt = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARB;
      ptr   <= '0;
      owner <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      owner <= owner_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_gray  <= '0;
      out_id    <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_gray  <= gnt_bin ^ (gnt_bin >> 1);
      out_id    <= gnt_id;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_enc_gray_arb.sv
// Scoreboard bench for enc_gray_arb: per-requester beat queues drive the DUT, expected {id,gray} queued at stimulus time.
module tb_enc_gray_arb;
  localparam int NREQ  = 4;
  localparam int WIDTH = 10;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_lock;
  logic [NREQ*WIDTH-1:0] req_bin;
  logic [NREQ-1:0]       req_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_gray;
  logic [IDW-1:0]        out_id;

  always #5 clk = ~clk;

  enc_gray_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_lock(req_lock), .req_bin(req_bin), .req_ready(req_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_gray(out_gray), .out_id(out_id)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [11:0]     sb[$];
  logic [10:0]     rq[NREQ][$];
  logic [NREQ-1:0] rr_seen;
  logic [NREQ-1:0] xfer;
  logic            hold_armed;
  logic [11:0]     held;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] g(input logic [9:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic push_beat(input int r, input logic lk, input logic [9:0] b);
    rq[r].push_back({lk, b});
  endtask

  task automatic expect_out(input int id, input logic [9:0] gray);
    sb.push_back({2'(id), gray});
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      if (rq[i].size() > 0) begin
        req_valid[i] = 1'b1;
        req_lock[i]  = rq[i][0][10];
        req_bin[i*WIDTH +: WIDTH] = rq[i][0][9:0];
      end else begin
        req_valid[i] = 1'b0;
        req_lock[i]  = 1'b0;
        req_bin[i*WIDTH +: WIDTH] = '0;
      end
    end
  endtask

  // One clock: observe at negedge, retire accepted beats and re-drive just after posedge.
  task automatic step();
    logic [11:0] e;
    @(negedge clk);
    rr_seen = req_ready;
    check("onehot", 32'($countones(req_ready) <= 1), 1);
    if (hold_armed) check("hold", {out_id, out_gray}, held);
    if (out_valid && out_ready) begin
      check("sb_nonempty", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("result", {out_id, out_gray}, e);
      end
    end
    hold_armed = out_valid && !out_ready;
    held       = {out_id, out_gray};
    xfer       = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) if (xfer[i]) void'(rq[i].pop_front());
    drive();
  endtask

  task automatic run_until_empty(input int budget, input string tag, output int cyc);
    cyc = 0;
    while (sb.size() > 0 && cyc < budget) begin
      step();
      cyc++;
    end
    check({tag, "_done"}, sb.size(), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    hold_armed = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [9:0] t2_bin  [4];
    logic [9:0] t2_gray [4];
    int cyc;
    t2_bin  = '{10'h000, 10'h155, 10'h3FF, 10'h001};
    t2_gray = '{10'h000, 10'h1FF, 10'h200, 10'h001};

    rst_n = 1'b0; out_ready = 1'b1; hold_armed = 1'b0;
    req_valid = '1; req_lock = '0; req_bin = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_gray", out_gray, 0);
    check("rst_out_id", out_id, 0);
    check("rst_req_ready", req_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive();

    // Single request from requester 2.
    push_beat(2, 1'b0, 10'h2AA); expect_out(2, 10'h3FF);
    drive();
    step();
    check("t1_grant", rr_seen, 4'b0100);
    step();
    check("t1_latency", sb.size(), 0);

    // All four requesters streaming: strict rotation, one result per cycle.
    do_reset();
    for (int rep = 0; rep < 2; rep++)
      for (int r = 0; r < NREQ; r++) begin
        push_beat(r, 1'b0, t2_bin[r]);
        expect_out(r, t2_gray[r]);
      end
    drive();
    run_until_empty(20, "t2", cyc);
    check("t2_cycles", cyc, 9);

    // Back-pressure then drain-and-refill on one edge.
    do_reset();
    out_ready = 1'b0;
    push_beat(0, 1'b0, 10'h0F0); expect_out(0, g(10'h0F0));
    push_beat(1, 1'b0, 10'h123); expect_out(1, g(10'h123));
    drive();
    step();
    check("t3_first", rr_seen, 4'b0001);
    for (int i = 0; i < 4; i++) begin
      step();
      check("t3_stall", rr_seen, 4'b0000);
    end
    out_ready = 1'b1;
    step();
    check("t3_refill", rr_seen, 4'b0010);
    check("t3_valid_kept", out_valid, 1);
    run_until_empty(5, "t3", cyc);

    // Locked burst from requester 1 with 0 and 3 waiting; pointer primed to 1.
    do_reset();
    push_beat(0, 1'b0, 10'h011); expect_out(0, g(10'h011));
    drive();
    run_until_empty(5, "t4a", cyc);
    push_beat(1, 1'b1, 10'h0A0); expect_out(1, g(10'h0A0));
    push_beat(1, 1'b1, 10'h0A1); expect_out(1, g(10'h0A1));
    push_beat(1, 1'b0, 10'h0A2); expect_out(1, g(10'h0A2));
    push_beat(3, 1'b0, 10'h0FF); expect_out(3, g(10'h0FF));
    push_beat(0, 1'b0, 10'h3C3); expect_out(0, g(10'h3C3));
    drive();
    run_until_empty(15, "t4", cyc);
    check("t4_cycles", cyc, 6);

    // Lock abort: owner 2 drops valid for a cycle.
    do_reset();
    push_beat(2, 1'b1, 10'h155); expect_out(2, g(10'h155));
    drive();
    step();
    check("t5_lock_grant", rr_seen, 4'b0100);
    push_beat(3, 1'b0, 10'h222); expect_out(3, g(10'h222));
    push_beat(0, 1'b0, 10'h333); expect_out(0, g(10'h333));
    drive();
    step();
    check("t5_abort_idle", rr_seen, 4'b0000);
    push_beat(2, 1'b0, 10'h044); expect_out(2, g(10'h044));
    drive();
    step();
    check("t5_after_abort", rr_seen, 4'b1000);
    run_until_empty(10, "t5", cyc);

    // Reset while locked with a held output.
    do_reset();
    out_ready = 1'b0;
    push_beat(1, 1'b1, 10'h100);
    push_beat(1, 1'b0, 10'h101);
    drive();
    step();
    check("t6_lock_grant", rr_seen, 4'b0010);
    check("t6_held_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    hold_armed = 1'b0;
    #1;
    check("t6_async_clr", out_valid, 0);
    check("t6_rdy_rst", req_ready, 0);
    push_beat(0, 1'b0, 10'h200); expect_out(0, g(10'h200));
    expect_out(1, g(10'h101));
    push_beat(3, 1'b0, 10'h300); expect_out(3, g(10'h300));
    drive();
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    check("t6_first", rr_seen, 4'b0001);
    run_until_empty(10, "t6", cyc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
